// File: rtl/adbg_jsp_16550_pkg.sv
`default_nettype none
// adbg_jsp_16550_pkg: register map and bit positions of the JSP 16550-style register set.
// Rev 1.0
package adbg_jsp_16550_pkg;

  localparam logic [2:0] ADDR_RBR_THR = 3'd0;
  localparam logic [2:0] ADDR_IER     = 3'd1;
  localparam logic [2:0] ADDR_IIR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR     = 3'd3;
  localparam logic [2:0] ADDR_LSR     = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  // 8N1 with DLAB clear; FCR value clears both FIFOs
  localparam logic [7:0] LCR_8N1       = 8'h03;
  localparam logic [7:0] FCR_CLR_FIFOS = 8'h06;

endpackage
`default_nettype wire

// File: rtl/adbg_apb_xfer.sv
`default_nettype none
// adbg_apb_xfer: single-initiator APB SETUP/ACCESS engine with an ACCESS-phase timeout.
// Rev 1.0
module adbg_apb_xfer #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic       slverr,
  output logic       timeout,
  output logic [7:0] rdata,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [2:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  logic              access;
  logic [TCNT_W-1:0] tcnt;

  // req is held by the sequencer for the whole transfer; the first cycle of req is SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access <= 1'b0;
      tcnt   <= '0;
    end else if (!access) begin
      tcnt <= '0;
      if (req) access <= 1'b1;
    end else if (done || timeout) begin
      access <= 1'b0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign psel    = req;
  assign penable = req & access;
  assign pwrite  = req & we;
  assign paddr   = req ? addr  : 3'd0;
  assign pwdata  = req ? wdata : 8'd0;

  assign done    = penable & pready;
  assign slverr  = done & pslverr;
  assign timeout = penable & ~pready & (tcnt == TCNT_LAST);
  assign rdata   = prdata;

endmodule
`default_nettype wire

// File: rtl/adbg_jsp_apb_host.sv
`default_nettype none
// adbg_jsp_apb_host: APB host that configures the JSP 16550 registers, then polls LSR
// and moves bytes between valid/ready streams and RBR/THR.  Rev 1.0
module adbg_jsp_apb_host
  import adbg_jsp_16550_pkg::*;
#(
  parameter int         POLL_DLY = 16,
  parameter int         TIMEOUT  = 64,
  parameter logic [3:0] IER_VAL  = 4'h0
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [2:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic       int_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       err_o,
  input  logic       err_clr_i
);

  typedef enum logic [2:0] {
    CFG_LCR = 3'd0,
    CFG_FCR = 3'd1,
    CFG_IER = 3'd2,
    WAIT    = 3'd3,
    RD_LSR  = 3'd4,
    RD_RBR  = 3'd5,
    WR_THR  = 3'd6
  } seq_state_t;

  localparam int WAIT_W = (POLL_DLY < 1) ? 1 : $clog2(POLL_DLY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(POLL_DLY);

  seq_state_t        state;
  logic              req;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lsr_thre;

  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       done, slverr, timeout;
  logic [7:0] rdata;
  logic       xfer_end, lsr_ok;

  assign xfer_end = done | timeout;
  assign lsr_ok   = done & ~slverr;

  always_comb begin
    we    = 1'b0;
    addr  = 3'd0;
    wdata = 8'd0;
    case (state)
      CFG_LCR: begin we = 1'b1; addr = ADDR_LCR;     wdata = LCR_8N1;         end
      CFG_FCR: begin we = 1'b1; addr = ADDR_IIR_FCR; wdata = FCR_CLR_FIFOS;   end
      CFG_IER: begin we = 1'b1; addr = ADDR_IER;     wdata = {4'h0, IER_VAL}; end
      RD_LSR:  addr = ADDR_LSR;
      RD_RBR:  addr = ADDR_RBR_THR;
      WR_THR:  begin we = 1'b1; addr = ADDR_RBR_THR; wdata = tx_data_i;       end
      default: ;
    endcase
  end

  // Transfer states keep req high across back-to-back transfers; WAIT is the only idle state
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= CFG_LCR;
      req        <= 1'b0;
      wait_cnt   <= '0;
      lsr_thre   <= 1'b0;
      rx_data_o  <= 8'd0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      tx_ready_o <= 1'b0;
      if (slverr || timeout) err_o <= 1'b1;
      else if (err_clr_i)    err_o <= 1'b0;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;

      if (state == WAIT) begin
        if (wait_cnt == '0 || int_i) begin
          state <= RD_LSR;
          req   <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
      end else if (!req) begin
        req <= 1'b1;
      end else if (xfer_end) begin
        case (state)
          CFG_LCR: state <= CFG_FCR;
          CFG_FCR: state <= CFG_IER;
          RD_LSR: begin
            lsr_thre <= rdata[LSR_THRE];
            if (lsr_ok && rdata[LSR_DR] && !rx_valid_o) begin
              state <= RD_RBR;
            end else if (lsr_ok && rdata[LSR_THRE] && tx_valid_i) begin
              state <= WR_THR;
            end else begin
              state <= WAIT; req <= 1'b0; wait_cnt <= WAIT_LOAD;
            end
          end
          RD_RBR: begin
            if (lsr_ok) begin
              rx_data_o  <= rdata;
              rx_valid_o <= 1'b1;
            end
            if (done && lsr_thre && tx_valid_i) begin
              state <= WR_THR;
            end else begin
              state <= WAIT; req <= 1'b0; wait_cnt <= WAIT_LOAD;
            end
          end
          WR_THR: begin
            if (done) tx_ready_o <= 1'b1;
            state <= WAIT; req <= 1'b0; wait_cnt <= WAIT_LOAD;
          end
          default: begin
            state <= WAIT; req <= 1'b0; wait_cnt <= WAIT_LOAD;
          end
        endcase
      end
    end
  end

  adbg_apb_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .done    (done),
    .slverr  (slverr),
    .timeout (timeout),
    .rdata   (rdata),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .paddr   (PADDR),
    .pwdata  (PWDATA),
    .prdata  (PRDATA),
    .pready  (PREADY),
    .pslverr (PSLVERR)
  );

endmodule
`default_nettype wire

// File: tb/tb_adbg_jsp_apb_host.sv
`default_nettype none
// tb_adbg_jsp_apb_host: directed self-checking bench with a JSP slave model.
// Rev 1.0
module tb_adbg_jsp_apb_host;

  localparam int         POLL_DLY = 2;
  localparam int         TIMEOUT  = 4;
  localparam logic [3:0] IER_VAL  = 4'h5;

  logic       PCLK, PRESETn;
  logic       PSEL, PENABLE, PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;
  logic       int_i, tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i, err_o, err_clr_i;
  logic [7:0] tx_data_i, rx_data_o;

  logic [7:0] lsr_val, rbr_val;
  logic       hold_all, hold_thr, slverr_rbr;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rel_cyc, base, txr_base, idx;
  int n_txr = 0;
  int stall_run = 0;
  int last_stall = 0;

  typedef struct {
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    int         cyc;
  } xfer_t;
  xfer_t xq[$];

  adbg_jsp_apb_host #(.POLL_DLY(POLL_DLY), .TIMEOUT(TIMEOUT), .IER_VAL(IER_VAL)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .int_i(int_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .err_o(err_o), .err_clr_i(err_clr_i)
  );

  // JSP slave: ready in the first ACCESS cycle unless told to stall
  assign PREADY  = PSEL & PENABLE & ~hold_all & ~(hold_thr & PWRITE & (PADDR == 3'd0));
  assign PRDATA  = (PADDR == 3'd5) ? lsr_val : rbr_val;
  assign PSLVERR = PREADY & slverr_rbr & ~PWRITE & (PADDR == 3'd0);

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    if (PSEL && PENABLE && PREADY) xq.push_back('{PWRITE, PADDR, PWDATA, cyc});
    if (tx_ready_o) n_txr++;
    if (PSEL && PENABLE && !PREADY) stall_run++;
    else begin
      if (stall_run > 0) last_stall = stall_run;
      stall_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [11:0] get(input int i);
    if (i < 0 || i >= xq.size()) return 12'hfff;
    return {xq[i].w, xq[i].a, xq[i].d};
  endfunction

  function automatic int count_x(input int from, input logic w, input logic [2:0] a);
    int n = 0;
    for (int i = from; i < xq.size(); i++) if (xq[i].w == w && xq[i].a == a) n++;
    return n;
  endfunction

  function automatic int find_x(input int from, input logic w, input logic [2:0] a);
    for (int i = from; i < xq.size(); i++) if (xq[i].w == w && xq[i].a == a) return i;
    return -1;
  endfunction

  initial begin
    PRESETn = 1'b0; int_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = 8'h00;
    rx_ready_i = 1'b0; err_clr_i = 1'b0;
    lsr_val = 8'h00; rbr_val = 8'h00; hold_all = 1'b0; hold_thr = 1'b0; slverr_rbr = 1'b0;
    repeat (3) tick();

    check("rst_ctrl", {PSEL, PENABLE, PWRITE}, 3'b000);
    check("rst_paddr", PADDR, 3'd0);
    check("rst_pwdata", PWDATA, 8'h00);
    check("rst_streams", {rx_data_o, rx_valid_o, tx_ready_o, err_o}, 11'd0);

    // configuration sequence and first poll
    PRESETn = 1'b1;
    rel_cyc = cyc;
    for (int i = 0; i < 200 && xq.size() < 4; i++) tick();
    check("cfg_lcr", get(0), {1'b1, 3'd3, 8'h03});
    check("cfg_fcr", get(1), {1'b1, 3'd2, 8'h06});
    check("cfg_ier", get(2), {1'b1, 3'd1, 4'h0, IER_VAL});
    check("first_lsr", get(3) >> 8, {1'b0, 3'd5});
    // SETUP of the first LSR read sits 6+POLL_DLY+1 cycles after the first released edge
    check("first_lsr_time", (xq.size() > 3) ? xq[3].cyc - rel_cyc : -1, 1 + (6 + POLL_DLY + 1) + 1);

    // receive with a stalled consumer
    rbr_val = 8'h5A; lsr_val = 8'h61;
    for (int i = 0; i < 100 && !rx_valid_o; i++) tick();
    check("rx_valid", rx_valid_o, 1'b1);
    check("rx_data", rx_data_o, 8'h5A);
    base = xq.size();
    for (int i = 0; i < 100 && count_x(base, 1'b0, 3'd5) < 2; i++) tick();
    check("rx_hold_polls", count_x(base, 1'b0, 3'd5) >= 2, 1'b1);
    check("rx_hold_no_rbr", count_x(base, 1'b0, 3'd0), 0);
    rbr_val = 8'h3C;
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    check("rx_clear", rx_valid_o, 1'b0);
    for (int i = 0; i < 100 && !rx_valid_o; i++) tick();
    check("rx_second", {rx_valid_o, rx_data_o}, {1'b1, 8'h3C});
    lsr_val = 8'h00; rx_ready_i = 1'b1;
    repeat (4) tick();

    // transmit
    txr_base = n_txr; base = xq.size();
    lsr_val = 8'h60; tx_data_i = 8'hA5; tx_valid_i = 1'b1;
    for (int i = 0; i < 100 && n_txr == txr_base; i++) tick();
    tx_valid_i = 1'b0;
    repeat (10) tick();
    check("tx_pulses", n_txr - txr_base, 1);
    check("tx_writes", count_x(base, 1'b1, 3'd0), 1);
    check("tx_data", get(find_x(base, 1'b1, 3'd0)), {1'b1, 3'd0, 8'hA5});

    // THR not empty: no write
    lsr_val = 8'h00; txr_base = n_txr; base = xq.size();
    tx_data_i = 8'h77; tx_valid_i = 1'b1;
    for (int i = 0; i < 100 && count_x(base, 1'b0, 3'd5) < 3; i++) tick();
    check("tx_blocked_writes", count_x(base, 1'b1, 3'd0), 0);
    check("tx_blocked_pulse", n_txr - txr_base, 0);
    tx_valid_i = 1'b0;

    // RX and TX pending on the same poll
    rx_ready_i = 1'b0; txr_base = n_txr; base = xq.size();
    lsr_val = 8'h61; rbr_val = 8'h11; tx_data_i = 8'h22; tx_valid_i = 1'b1;
    for (int i = 0; i < 100 && n_txr == txr_base; i++) tick();
    tx_valid_i = 1'b0;
    idx = find_x(base, 1'b0, 3'd0);
    check("both_rbr_seen", idx >= 0, 1'b1);
    check("both_lsr_then_rbr", get(idx - 1) >> 8, {1'b0, 3'd5});
    check("both_rbr_then_thr", get(idx + 1), {1'b1, 3'd0, 8'h22});
    check("both_rx_data", {rx_valid_o, rx_data_o}, {1'b1, 8'h11});
    lsr_val = 8'h00; rx_ready_i = 1'b1;
    repeat (6) tick();

    // THR write that never gets PREADY
    txr_base = n_txr;
    hold_thr = 1'b1; lsr_val = 8'h60; tx_data_i = 8'h99; tx_valid_i = 1'b1;
    for (int i = 0; i < 200 && !err_o; i++) tick();
    check("to_err", err_o, 1'b1);
    check("to_psel_drop", PSEL, 1'b0);
    tick();
    check("to_access_cycles", last_stall, TIMEOUT);
    check("to_not_consumed", n_txr - txr_base, 0);
    for (int i = 0; i < 100 && !(PSEL && PWRITE); i++) tick();
    check("to_retry", PSEL & PWRITE & (PADDR == 3'd0), 1'b1);
    hold_thr = 1'b0;
    for (int i = 0; i < 100 && n_txr == txr_base; i++) tick();
    tx_valid_i = 1'b0;
    check("to_retry_consumed", n_txr - txr_base, 1);
    lsr_val = 8'h00;
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("err_clear", err_o, 1'b0);

    // PSLVERR on RBR while err_clr_i is held: the set must win
    rx_ready_i = 1'b0; rbr_val = 8'h44; slverr_rbr = 1'b1; lsr_val = 8'h61;
    err_clr_i = 1'b1;
    for (int i = 0; i < 100 && !err_o; i++) tick();
    err_clr_i = 1'b0;
    check("slverr_err", err_o, 1'b1);
    repeat (2) tick();
    check("slverr_no_rx", rx_valid_o, 1'b0);
    lsr_val = 8'h00; slverr_rbr = 1'b0;
    repeat (12) tick();

    // asynchronous reset in the middle of an ACCESS phase
    hold_all = 1'b1;
    for (int i = 0; i < 100 && !(PSEL && PENABLE); i++) tick();
    check("mid_access", PSEL & PENABLE, 1'b1);
    PRESETn = 1'b0;
    #1;
    check("rst_drop", {PSEL, PENABLE, err_o}, 3'b000);
    hold_all = 1'b0;
    repeat (2) tick();
    PRESETn = 1'b1;
    base = xq.size();
    for (int i = 0; i < 100 && xq.size() < base + 3; i++) tick();
    check("restart_lcr", get(base), {1'b1, 3'd3, 8'h03});
    check("restart_ier", get(base + 2), {1'b1, 3'd1, 4'h0, IER_VAL});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
